dcache_wb_controller: RTL and testbench
=======================================

Name: dcache_wb_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU core's dcache_* ports and the off-chip memory request interface.
- Produces the core's global `stall`.
- Hits return data one cycle after the request; misses hold `stall` high while the block evicts the old line if dirty, then refills.
- Sits directly downstream of the CPU datapath's memory stage, inside the memory subsystem.

Parameters:
- LINES, 64, number of cache lines (power of 2, ≥2).
- Line size is fixed at 16 bytes (4 words). A parameter for it is not provided.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- dcache_addr  in  32  byte address from core (bits [1:0] ignored)
- dcache_re  in  1  load request
- dcache_we  in  4  byte write enables; nonzero = store
- dcache_din  in  32  store data, byte lanes already aligned
- dcache_dout  out  32  load data
- stall  out  1  freezes the core pipeline
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_rnw  out  1  1 = line read, 0 = line write
- mem_req_addr  out  32  line address, bits [3:0] = 0
- mem_req_data  out  128  write-back line data; word k at bits [32k+31:32k]
- mem_resp_valid  in  1  refill data valid (one beat)
- mem_resp_data  in  128  refill line data, same packing

Behaviour:
- Address fields:
  - offset word = addr[3:2]
  - index = addr[3+log2(LINES):4]
  - tag = remaining upper bits
- Per line: valid bit, dirty bit, tag, 128-bit data.
- Request capture:
  - At a posedge with stall=0 and (dcache_re | |dcache_we), register addr/re/we/din as the pending request.
  - Inputs are ignored while stall=1; the core holds them.
- Lookup cycle (cycle after capture): hit = valid[index] && tag match.
  - Load hit: dcache_dout = line word, combinational from the arrays; stall=0.
  - Store hit: merge enabled bytes at the next edge and set dirty; stall=0.
  - dcache_dout is don't-care for stores.
  - Miss: stall=1 combinationally in this same cycle, and the FSM leaves IDLE.
- Back-to-back hits are accepted every cycle.
- FSM states: IDLE, WB, REFILL_REQ, REFILL_WAIT, DONE.
  - IDLE→WB on a miss with a dirty victim.
  - IDLE→REFILL_REQ on a miss with a clean or invalid victim.
  - WB:
    - drives mem_req_valid=1, rnw=0, addr={victim tag,index,4'b0}, data=victim line
    - on mem_req_ready → REFILL_REQ
  - REFILL_REQ:
    - drives mem_req_valid=1, rnw=1, addr={req tag,index,4'b0}
    - on mem_req_ready → REFILL_WAIT
  - REFILL_WAIT:
    - on mem_resp_valid, write the line, tag and valid=1
    - if the pending request is a store, merge its bytes into the line in the same write and set dirty=1; otherwise dirty=0
    - → DONE
  - DONE:
    - stall=0
    - dcache_dout = requested word of the new line
    - a new request may be captured at this edge
    - → IDLE
- stall = 1 in WB, REFILL_REQ, REFILL_WAIT, and in IDLE on a pending miss; otherwise 0.
- mem_req_* outputs stay stable while valid=1 and ready=0; valid=1 and ready=1 completes in one cycle.
- mem_resp_valid outside REFILL_WAIT is ignored.
- Reset (any state, mid-transaction included) at the clocked edge:
  - all valid=0, dirty=0
  - FSM=IDLE, pending request cleared
  - stall=0, mem_req_valid=0, dcache_dout=0
  - The memory side shares rst, so no outstanding response survives reset.
- Aliasing: two addresses with the same index and different tag evict each other; a dirty victim is always written back before the refill request issues.
- Store miss to a line whose victim is invalid: no WB state.
- Latency:
  - hit: 1 cycle
  - clean miss: 3 cycles + memory latency
  - dirty miss: additionally one WB handshake

Test Plan:
- Reset, then load 0x1000_0040 (cold) → stall=1 next cycle, REFILL_REQ addr=0x1000_0040 rnw=1; respond with words {0x11,0x22,0x33,0x44} → in DONE, dout=0x11 and stall=0; reload the same address → hit, dout=0x11 in 1 cycle, no mem_req.
- Store we=4'b0010, din=0x0000_AB00 to 0x1000_0044 (hit) → no stall; load 0x1000_0044 → 0x0000_AB22.
- Load 0x1000_0440 (same index for LINES=64, different tag) → WB of line 0x1000_0040 with data {0x11,0xAB22,0x33,0x44}, then REFILL_REQ 0x1000_0440, dout from the new line.
- Hold mem_req_ready=0 for 5 cycles in WB → valid/addr/data stable, stall=1 throughout; mem_resp_valid pulsed in REFILL_REQ is ignored.
- Store miss we=4'b1111, din=0xDEAD_BEEF to 0x1000_0808 on an invalid line → refill, word 2 = 0xDEAD_BEEF, dirty=1; a later eviction writes it back.
- Assert rst during REFILL_WAIT → next cycle stall=0, mem_req_valid=0; load 0x1000_0440 → misses again, since all lines are invalid.

Source files
------------

// File: rtl/dcache_wb_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Sits between the core memory stage and a line-granular memory request port.
module dcache_wb_controller #(
    parameter int unsigned LINES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  dcache_addr,
    input  logic         dcache_re,
    input  logic [3:0]   dcache_we,
    input  logic [31:0]  dcache_din,
    output logic [31:0]  dcache_dout,
    output logic         stall,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic         mem_req_rnw,
    output logic [31:0]  mem_req_addr,
    output logic [127:0] mem_req_data,
    input  logic         mem_resp_valid,
    input  logic [127:0] mem_resp_data
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 28 - IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_REFILL_REQ,
        S_REFILL_WAIT,
        S_DONE
    } state_t;

    state_t state;

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [127:0]     data_mem [LINES];

    // Pending request; the byte offset is dropped at capture.
    logic        req_valid;
    logic [29:0] req_addr;
    logic [3:0]  req_we;
    logic [31:0] req_din;

    logic [1:0]       req_word;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             is_store;
    logic             hit;
    logic             miss;
    logic             new_req;
    logic             line_we;
    logic             fill_we;
    logic [127:0]     line_wdata;
    logic [127:0]     cur_line;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^dcache_addr[1:0];

    assign req_word = req_addr[1:0];
    assign req_idx  = req_addr[2 +: IDX_W];
    assign req_tag  = req_addr[29 -: TAG_W];
    assign is_store = |req_we;
    assign cur_line = data_mem[req_idx];
    assign new_req  = dcache_re | (|dcache_we);

    // Merge the enabled byte lanes of a store word into a line.
    function automatic logic [127:0] merge_line(
        input logic [127:0] line,
        input logic [1:0]   word,
        input logic [3:0]   we,
        input logic [31:0]  din
    );
        logic [127:0] r;
        r = line;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) r[32*int'(word) + 8*b +: 8] = din[8*b +: 8];
        end
        return r;
    endfunction

    // Lookup, stall and memory-port decode from state and the arrays.
    always_comb begin
        hit           = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
        miss          = (state == S_IDLE) && req_valid && !hit;
        stall         = miss || (state == S_WB) || (state == S_REFILL_REQ) ||
                        (state == S_REFILL_WAIT);
        dcache_dout   = req_valid ? cur_line[32*int'(req_word) +: 32] : 32'h0;
        mem_req_valid = (state == S_WB) || (state == S_REFILL_REQ);
        mem_req_rnw   = (state != S_WB);
        mem_req_addr  = (state == S_WB) ? {tag_mem[req_idx], req_idx, 4'b0000}
                                        : {req_tag, req_idx, 4'b0000};
        mem_req_data  = cur_line;
        fill_we       = !rst && (state == S_REFILL_WAIT) && mem_resp_valid;
        line_we       = fill_we ||
                        (!rst && (state == S_IDLE) && req_valid && hit && is_store);
        if (state == S_REFILL_WAIT) begin
            line_wdata = is_store ? merge_line(mem_resp_data, req_word, req_we, req_din)
                                  : mem_resp_data;
        end else begin
            line_wdata = merge_line(cur_line, req_word, req_we, req_din);
        end
    end

    // Line data and tag storage (not reset; qualified by valid).
    always_ff @(posedge clk) begin
        if (line_we) data_mem[req_idx] <= line_wdata;
        if (fill_we) tag_mem[req_idx] <= req_tag;
    end

    // Miss-handling FSM, valid/dirty bits and request capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            req_valid <= 1'b0;
            req_addr  <= '0;
            req_we    <= '0;
            req_din   <= '0;
            valid_q   <= '0;
            dirty_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss) begin
                        state <= (valid_q[req_idx] && dirty_q[req_idx]) ? S_WB : S_REFILL_REQ;
                    end else if (req_valid && is_store) begin
                        dirty_q[req_idx] <= 1'b1;
                    end
                end
                S_WB: begin
                    if (mem_req_ready) state <= S_REFILL_REQ;
                end
                S_REFILL_REQ: begin
                    if (mem_req_ready) state <= S_REFILL_WAIT;
                end
                S_REFILL_WAIT: begin
                    if (mem_resp_valid) begin
                        valid_q[req_idx] <= 1'b1;
                        dirty_q[req_idx] <= is_store;
                        state            <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (!stall) begin
                req_valid <= new_req;
                if (new_req) begin
                    req_addr <= dcache_addr[31:2];
                    req_we   <= dcache_we;
                    req_din  <= dcache_din;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_wb_controller.sv
// Directed self-checking bench for dcache_wb_controller (LINES=64).
module tb_dcache_wb_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dcache_addr;
    logic         dcache_re;
    logic [3:0]   dcache_we;
    logic [31:0]  dcache_din;
    logic [31:0]  dcache_dout;
    logic         stall;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rnw;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;

    int checks   = 0;
    int failures = 0;

    dcache_wb_controller #(.LINES(64)) dut (
        .clk(clk), .rst(rst),
        .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
        .dcache_din(dcache_din), .dcache_dout(dcache_dout), .stall(stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rnw(mem_req_rnw), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        dcache_re = 1'b0; dcache_we = 4'b0; dcache_addr = '0; dcache_din = '0;
    endtask

    task automatic req_load(input logic [31:0] a);
        dcache_re = 1'b1; dcache_we = 4'b0; dcache_addr = a; dcache_din = '0;
    endtask

    task automatic req_store(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        dcache_re = 1'b0; dcache_we = we; dcache_addr = a; dcache_din = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_in();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", mem_req_valid); end
        checks++; if (dcache_dout !== 32'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dcache_dout); end
        tick();
    endtask

    task automatic test_cold_load();
        req_load(32'h1000_0040); tick();
        checks++; if (stall !== 1'b1 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL cold_miss_stall stall=%b valid=%b exp 1/0", stall, mem_req_valid); end
        tick();
        checks++; if ({mem_req_valid, mem_req_rnw, stall} !== 3'b111 || mem_req_addr !== 32'h1000_0040) begin
            failures++; $display("FAIL cold_refill_req v/rnw/stall=%b addr=%h exp 111 10000040", {mem_req_valid, mem_req_rnw, stall}, mem_req_addr); end
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        checks++; if (mem_req_valid !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL cold_wait valid=%b stall=%b exp 0/1", mem_req_valid, stall); end
        mem_resp_valid = 1'b1; mem_resp_data = {32'h44, 32'h33, 32'h22, 32'h11};
        tick(); mem_resp_valid = 1'b0;
        checks++; if (stall !== 1'b0 || dcache_dout !== 32'h11) begin failures++; $display("FAIL cold_done stall=%b dout=%h exp 0 00000011", stall, dcache_dout); end
        req_load(32'h1000_0040); tick();
        checks++; if (stall !== 1'b0 || dcache_dout !== 32'h11 || mem_req_valid !== 1'b0) begin
            failures++; $display("FAIL reload_hit stall=%b dout=%h valid=%b exp 0 00000011 0", stall, dcache_dout, mem_req_valid); end
    endtask

    task automatic test_store_hit();
        req_store(32'h1000_0044, 4'b0010, 32'h0000_AB00); tick();
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL store_hit_stall got=%b exp=0", stall); end
        req_load(32'h1000_0044); tick();
        checks++; if (stall !== 1'b0 || dcache_dout !== 32'h0000_AB22) begin failures++; $display("FAIL store_merge stall=%b dout=%h exp 0 0000ab22", stall, dcache_dout); end
    endtask

    task automatic test_dirty_evict();
        logic [127:0] victim;
        victim = {32'h44, 32'h33, 32'h0000_AB22, 32'h11};
        req_load(32'h1000_0440); tick();
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL evict_miss_stall got=%b exp=1", stall); end
        tick();
        checks++; if ({mem_req_valid, mem_req_rnw} !== 2'b10 || mem_req_addr !== 32'h1000_0040 || mem_req_data !== victim) begin
            failures++; $display("FAIL wb_req v/rnw=%b addr=%h data=%h exp 10 10000040 %h", {mem_req_valid, mem_req_rnw}, mem_req_addr, mem_req_data, victim); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({mem_req_valid, mem_req_rnw, stall} !== 3'b101 || mem_req_addr !== 32'h1000_0040 || mem_req_data !== victim) begin
                failures++; $display("FAIL wb_hold cyc=%0d v/rnw/stall=%b addr=%h exp 101 10000040", i, {mem_req_valid, mem_req_rnw, stall}, mem_req_addr); end
        end
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        checks++; if ({mem_req_valid, mem_req_rnw} !== 2'b11 || mem_req_addr !== 32'h1000_0440) begin
            failures++; $display("FAIL evict_refill_req v/rnw=%b addr=%h exp 11 10000440", {mem_req_valid, mem_req_rnw}, mem_req_addr); end
        mem_resp_valid = 1'b1; mem_resp_data = {4{32'hBAD0_BAD0}}; tick(); mem_resp_valid = 1'b0;
        checks++; if ({mem_req_valid, mem_req_rnw, stall} !== 3'b111 || mem_req_addr !== 32'h1000_0440) begin
            failures++; $display("FAIL stray_resp_ignored v/rnw/stall=%b addr=%h exp 111 10000440", {mem_req_valid, mem_req_rnw, stall}, mem_req_addr); end
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = {32'h88, 32'h77, 32'h66, 32'h55};
        tick(); mem_resp_valid = 1'b0;
        checks++; if (stall !== 1'b0 || dcache_dout !== 32'h55) begin failures++; $display("FAIL evict_done stall=%b dout=%h exp 0 00000055", stall, dcache_dout); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [4];
        exp_w = '{32'h55, 32'h66, 32'h77, 32'h88};
        for (int i = 0; i < 4; i++) begin
            req_load(32'h1000_0440 + 32'(4 * i)); tick();
            checks++; if (stall !== 1'b0 || dcache_dout !== exp_w[i] || mem_req_valid !== 1'b0) begin
                failures++; $display("FAIL b2b_hit w=%0d stall=%b dout=%h exp 0 %h", i, stall, dcache_dout, exp_w[i]); end
        end
        idle_in(); tick();
    endtask

    task automatic test_store_miss();
        req_store(32'h1000_0808, 4'b1111, 32'hDEAD_BEEF); tick();
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL smiss_stall got=%b exp=1", stall); end
        tick();
        checks++; if ({mem_req_valid, mem_req_rnw} !== 2'b11 || mem_req_addr !== 32'h1000_0800) begin
            failures++; $display("FAIL smiss_no_wb v/rnw=%b addr=%h exp 11 10000800", {mem_req_valid, mem_req_rnw}, mem_req_addr); end
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        tick(); mem_resp_valid = 1'b0;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL smiss_done stall=%b exp 0", stall); end
        req_load(32'h1000_0808); tick();
        checks++; if (stall !== 1'b0 || dcache_dout !== 32'hDEAD_BEEF) begin failures++; $display("FAIL smiss_readback stall=%b dout=%h exp 0 deadbeef", stall, dcache_dout); end
        req_load(32'h1000_0C00); tick();
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL smiss_evict_stall got=%b exp=1", stall); end
        tick();
        checks++; if ({mem_req_valid, mem_req_rnw} !== 2'b10 || mem_req_addr !== 32'h1000_0800 ||
                      mem_req_data !== {32'hA3, 32'hDEAD_BEEF, 32'hA1, 32'hA0}) begin
            failures++; $display("FAIL smiss_writeback v/rnw=%b addr=%h data=%h", {mem_req_valid, mem_req_rnw}, mem_req_addr, mem_req_data); end
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        checks++; if ({mem_req_valid, mem_req_rnw} !== 2'b11 || mem_req_addr !== 32'h1000_0C00) begin
            failures++; $display("FAIL smiss_refill2 v/rnw=%b addr=%h exp 11 10000c00", {mem_req_valid, mem_req_rnw}, mem_req_addr); end
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        tick(); mem_resp_valid = 1'b0;
        checks++; if (stall !== 1'b0 || dcache_dout !== 32'hB0) begin failures++; $display("FAIL smiss_done2 stall=%b dout=%h exp 0 000000b0", stall, dcache_dout); end
        idle_in(); tick();
    endtask

    task automatic test_reset_mid();
        req_load(32'h1000_0040); tick(); tick();
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        checks++; if (stall !== 1'b1 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL rmid_in_wait stall=%b valid=%b exp 1/0", stall, mem_req_valid); end
        rst = 1'b1; tick(); rst = 1'b0; idle_in();
        checks++; if (stall !== 1'b0 || mem_req_valid !== 1'b0 || dcache_dout !== 32'h0) begin
            failures++; $display("FAIL rmid_after stall=%b valid=%b dout=%h exp 0 0 0", stall, mem_req_valid, dcache_dout); end
        tick();
        req_load(32'h1000_0440); tick();
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rmid_remiss got=%b exp=1", stall); end
        tick();
        checks++; if ({mem_req_valid, mem_req_rnw} !== 2'b11 || mem_req_addr !== 32'h1000_0440) begin
            failures++; $display("FAIL rmid_refill v/rnw=%b addr=%h exp 11 10000440", {mem_req_valid, mem_req_rnw}, mem_req_addr); end
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        tick(); mem_resp_valid = 1'b0;
        checks++; if (stall !== 1'b0 || dcache_dout !== 32'hC0) begin failures++; $display("FAIL rmid_done stall=%b dout=%h exp 0 000000c0", stall, dcache_dout); end
        idle_in(); tick();
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_store_hit();
        test_dirty_evict();
        test_back_to_back();
        test_store_miss();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
